// File: rtl/cpu_regfile_sb_pkg.sv
// Default register-file geometry and the shared address/data types
// used by the decode/writeback register file.
package cpu_rf_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/cpu_regfile_sb_if.sv
// Decode/writeback bus of the register file: operand reads, writeback,
// destination issue, and the hazard stall returned to decode.
interface cpu_regfile_sb_if
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              stall;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data1, rd_data2, rd_valid, stall
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, rd_valid, stall
  );
endinterface

// File: rtl/cpu_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue and
// cleared at writeback, producing the operand-read stall.
module rf_scoreboard
  import cpu_rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              stall
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                pend1;
  logic                pend2;

  // Issue is applied after the writeback clear so a same-address pair leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)
      pending_nxt[wr_addr] = 1'b0;
    if (iss_en)
      pending_nxt[iss_addr] = 1'b1;
    if (ZERO_REG)
      pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  // A writeback landing this cycle resolves the hazard; bypass supplies the data.
  assign pend1 = pending[rd_addr1] & ~(wr_en & (wr_addr == rd_addr1));
  assign pend2 = pending[rd_addr2] & ~(wr_en & (wr_addr == rd_addr2));
  assign stall = rd_en & (pend1 | pend2);
endmodule

// File: rtl/cpu_regfile_sb.sv
// Two-read/one-write register file with registered, write-first reads,
// optional hardwired-zero r0 and an integrated pending-write scoreboard.
module cpu_regfile_sb
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  cpu_regfile_sb_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              stall;
  logic              rd_accept;
  logic [DATA_W-1:0] rd_data1_p1;
  logic [DATA_W-1:0] rd_data2_p1;
  logic              vld_p1;

  assign rd_en    = bus.rd_en;
  assign rd_addr1 = bus.rd_addr1;
  assign rd_addr2 = bus.rd_addr2;
  assign wr_en    = bus.wr_en;
  assign wr_addr  = bus.wr_addr;
  assign wr_data  = bus.wr_data;

  assign wr_commit = wr_en & ~(ZERO_REG && (wr_addr == '0));
  assign rd_accept = rd_en & ~stall;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG && (addr == '0))
      return '0;
    if (wr_commit && (wr_addr == addr))
      return wr_data;
    return regs[addr];
  endfunction

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .stall    (stall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Stage p1: registered operand data; held when the read is not accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data1_p1 <= '0;
      rd_data2_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= rd_accept;
      if (rd_accept) begin
        rd_data1_p1 <= read_port(rd_addr1);
        rd_data2_p1 <= read_port(rd_addr2);
      end
    end
  end

  assign bus.rd_data1 = rd_data1_p1;
  assign bus.rd_data2 = rd_data2_p1;
  assign bus.rd_valid = vld_p1;
  assign bus.stall    = stall;
endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Bench for cpu_regfile_sb: directed hazard/bypass sequences with literal
// expectations, then randomized traffic against an array-based reference model.
module tb_cpu_regfile_sb;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  cpu_regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] m_regs [16];
  bit          m_pend [16];
  logic [31:0] m_rd1;
  logic [31:0] m_rd2;
  logic        m_vld;
  logic        s_stall;
  int          n_chk;
  int          n_fail;

  function automatic logic [31:0] m_val(input logic [3:0] a, input logic we,
                                        input logic [3:0] wa, input logic [31:0] wd);
    if (a == 4'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus: apply, check stall, advance model, check outputs.
  task automatic drive(input logic rs, input logic re, input logic [3:0] a1, input logic [3:0] a2,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [3:0] ia);
    logic exp_stall;
    logic acc;
    @(negedge clk);
    reset = rs; bus.rd_en = re; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.iss_en = ie; bus.iss_addr = ia;
    #1;
    exp_stall = re && ((m_pend[a1] && !(we && wa == a1)) || (m_pend[a2] && !(we && wa == a2)));
    s_stall = bus.stall;
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
      m_rd1 = 32'd0; m_rd2 = 32'd0; m_vld = 1'b0;
    end else begin
      acc = re && !exp_stall;
      if (acc) begin
        m_rd1 = m_val(a1, we, wa, wd);
        m_rd2 = m_val(a2, we, wa, wd);
      end
      m_vld = acc;
      if (we && wa != 4'd0) m_regs[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (ie && ia != 4'd0) m_pend[ia] = 1'b1;
    end
    #1;
    chk("rd_data1", bus.rd_data1, m_rd1);
    chk("rd_data2", bus.rd_data2, m_rd2);
    chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_vld});
  endtask

  initial begin
    logic [3:0] last_iss;
    logic [3:0] wa;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
    m_rd1 = 32'd0; m_rd2 = 32'd0; m_vld = 1'b0;
    reset = 1'b1; bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.iss_en = 1'b0; bus.iss_addr = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset_data1", bus.rd_data1, 32'd0);

    drive(0, 1, 1, 2, 0, 0, 0, 0, 0);
    chk("rst_read_d1", bus.rd_data1, 32'd0);
    chk("rst_read_d2", bus.rd_data2, 32'd0);
    chk("rst_read_vld", {31'd0, bus.rd_valid}, 32'd1);
    chk("rst_read_stall", {31'd0, s_stall}, 32'd0);

    drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
    chk("r5_d1", bus.rd_data1, 32'hDEADBEEF);
    chk("r5_d2", bus.rd_data2, 32'hDEADBEEF);

    drive(0, 1, 3, 0, 1, 3, 32'h12345678, 0, 0);
    chk("bypass_d1", bus.rd_data1, 32'h12345678);
    chk("bypass_r0", bus.rd_data2, 32'd0);

    drive(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_zero", bus.rd_data1, 32'd0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
    drive(0, 1, 7, 1, 0, 0, 0, 0, 0);
    chk("hazard_stall", {31'd0, s_stall}, 32'd1);
    chk("hazard_vld", {31'd0, bus.rd_valid}, 32'd0);
    chk("hazard_hold", bus.rd_data1, 32'd0);
    drive(0, 1, 7, 1, 1, 7, 32'hA5A5A5A5, 0, 0);
    chk("resolve_stall", {31'd0, s_stall}, 32'd0);
    chk("resolve_d1", bus.rd_data1, 32'hA5A5A5A5);
    chk("resolve_vld", {31'd0, bus.rd_valid}, 32'd1);

    drive(0, 0, 0, 0, 1, 9, 32'h55, 1, 9);
    drive(0, 1, 9, 9, 0, 0, 0, 0, 0);
    chk("iss_wins_stall", {31'd0, s_stall}, 32'd1);

    drive(0, 0, 0, 0, 1, 11, 32'h1111, 1, 12);
    drive(0, 1, 5, 3, 1, 4, 32'h2222, 1, 13);
    drive(1, 1, 5, 7, 1, 6, 32'h3333, 1, 5);
    chk("midrst_vld", {31'd0, bus.rd_valid}, 32'd0);
    chk("midrst_d1", bus.rd_data1, 32'd0);
    drive(0, 1, 5, 9, 0, 0, 0, 0, 0);
    chk("postrst_stall", {31'd0, s_stall}, 32'd0);
    chk("postrst_d1", bus.rd_data1, 32'd0);
    chk("postrst_vld", {31'd0, bus.rd_valid}, 32'd1);

    last_iss = 4'd1;
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ia;
      ia = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 1) == 0) ? last_iss : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0), wa, $urandom,
            ($urandom_range(0, 2) == 0), ia);
      if (bus.iss_en) last_iss = ia;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
